// File: rtl/switch_toggle_bank.sv
// Multi-channel switch-to-LED controller. Each channel has a 2-flop synchroniser, a
// debounce counter, edge detection, a toggle register and a mode-selected LED driver.
module switch_toggle_bank #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic [1:0]        i_Mode,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Switch_Db,
    output logic [NUM_CH-1:0] o_Press,
    output logic [NUM_CH-1:0] o_Release
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    typedef enum logic [1:0] {
        MODE_TOGGLE_REL   = 2'b00,
        MODE_TOGGLE_PRESS = 2'b01,
        MODE_FOLLOW       = 2'b10,
        MODE_OFF          = 2'b11
    } mode_e;

    mode_e             mode;
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] db_q, db_d;
    logic [NUM_CH-1:0] db_d1_q;
    logic [NUM_CH-1:0] tg_q, tg_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] press, release_p;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];

    assign mode      = mode_e'(i_Mode);
    assign press     = db_q & ~db_d1_q;
    assign release_p = ~db_q & db_d1_q;

    // Any cycle where the synchronised input agrees with db restarts qualification.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            db_d[ch]  = db_q[ch];
            if (sync2_q[ch] == db_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                db_d[ch]  = sync2_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
        end
    end

    // LED samples next-state tg so it lights one cycle after the qualifying pulse.
    always_comb begin
        tg_d  = tg_q;
        led_d = '0;
        unique case (mode)
            MODE_TOGGLE_REL: begin
                tg_d  = tg_q ^ release_p;
                led_d = tg_d;
            end
            MODE_TOGGLE_PRESS: begin
                tg_d  = tg_q ^ press;
                led_d = tg_d;
            end
            MODE_FOLLOW: led_d = db_q;
            MODE_OFF:    led_d = '0;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            db_d1_q <= '0;
            tg_q    <= '0;
            led_q   <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            db_d1_q <= db_q;
            tg_q    <= tg_d;
            led_q   <= led_d;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign o_LED       = led_q;
    assign o_Switch_Db = db_q;
    assign o_Press     = press;
    assign o_Release   = release_p;

endmodule
